// File: rtl/pc_pkg.sv
// Shared types for the PIC24-style program counter: FSM states, the decoded
// command encoding and the default reset vector.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        CmdNone   = 3'd0,
        CmdRet    = 3'd1,
        CmdCall   = 3'd2,
        CmdLoad   = 3'd3,
        CmdBranch = 3'd4,
        CmdInc    = 3'd5
    } pc_cmd_e;

    localparam int PC_RESET_VEC = 0;

    // Only the highest-priority strobe survives; the rest are dropped.
    function automatic pc_cmd_e cmd_decode(
        input logic ret,
        input logic call,
        input logic load,
        input logic branch,
        input logic inc
    );
        pc_cmd_e cmd;
        if (ret)         cmd = CmdRet;
        else if (call)   cmd = CmdCall;
        else if (load)   cmd = CmdLoad;
        else if (branch) cmd = CmdBranch;
        else if (inc)    cmd = CmdInc;
        else             cmd = CmdNone;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Pushes into a full stack and pops from an empty stack
// are dropped; the pointer never wraps.
module pc_ret_stack #(
    parameter int ADDR_W      = 23,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic                               pop_i,
    input  logic [ADDR_W-1:0]                  din_i,
    output logic [ADDR_W-1:0]                  dout_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   cnt_o,
    output logic                               full_o,
    output logic                               empty_o
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // rd_idx is the current top entry; only meaningful while not empty.
    assign wr_idx = cnt_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);

    assign dout_o = mem_q[rd_idx];
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk_i) begin
        if (do_push && do_pop) begin
            mem_q[rd_idx] <= din_i;
        end else if (do_push) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, relative branch, two-word absolute load and
// CALL/RETURN through a hardware return-address stack.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 16,
    parameter int INC_STEP    = 2,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = PC_RESET_VEC
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              pcinc_i,
    input  logic                              pcload_i,
    input  logic                              branch_i,
    input  logic [DATA_W-1:0]                 boffs_i,
    input  logic                              call_i,
    input  logic                              ret_i,
    input  logic [DATA_W-1:0]                 databus_i,
    output logic [ADDR_W:0]                   pc_addr_o,
    output logic                              busy_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  stk_cnt_o,
    output logic                              stk_ovf_o,
    output logic                              stk_unf_o
);

    pc_state_e           state_q;
    pc_cmd_e             cmd;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   offs_ext;
    logic [ADDR_W-1:0]   pc_branch;
    logic [DATA_W-1:0]   lo_hold;
    logic [2*DATA_W-1:0] load_word;
    logic [ADDR_W-1:0]   stk_dout;
    logic                stk_push;
    logic                stk_pop;
    logic                stk_full;
    logic                stk_empty;
    logic                ovf_q;
    logic                unf_q;
    logic                unused_bits;

    // Commands are only decoded in IDLE; everything is ignored while loading.
    assign cmd = (state_q == IDLE)
               ? cmd_decode(ret_i, call_i, pcload_i, branch_i, pcinc_i)
               : CmdNone;

    assign pc_inc    = pc_q + ADDR_W'(INC_STEP);
    assign offs_ext  = ADDR_W'($signed(boffs_i));
    assign pc_branch = pc_inc + (offs_ext << 1);

    // The MSW arrives with the final edge so the PC updates in one step.
    assign load_word = {databus_i, lo_hold};

    assign stk_push = (cmd == CmdCall);
    assign stk_pop  = (cmd == CmdRet);

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_inc),
        .dout_o  (stk_dout),
        .cnt_o   (stk_cnt_o),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_VEC);
            lo_hold <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (cmd)
                        CmdRet: begin
                            if (stk_empty) unf_q <= 1'b1;
                            else           pc_q  <= stk_dout;
                        end
                        CmdCall: begin
                            if (stk_full) ovf_q <= 1'b1;
                            state_q <= LOAD_LO;
                        end
                        CmdLoad:   state_q <= LOAD_LO;
                        CmdBranch: pc_q    <= {pc_branch[ADDR_W-1:1], 1'b0};
                        CmdInc:    pc_q    <= pc_inc;
                        default:   pc_q    <= pc_q;
                    endcase
                end
                LOAD_LO: begin
                    lo_hold <= {databus_i[DATA_W-1:1], 1'b0};
                    state_q <= LOAD_HI;
                end
                LOAD_HI: begin
                    pc_q    <= {load_word[ADDR_W-1:1], 1'b0};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_addr_o = {1'b0, pc_q};
    assign busy_o    = (state_q != IDLE);
    assign stk_ovf_o = ovf_q;
    assign stk_unf_o = unf_q;

    assign unused_bits = ^{load_word, pc_branch[0]};

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with a queue-based reference model checked
// every cycle, plus literal expectations from hand-worked examples.
module tb_pc_stack_unit;

    localparam int     ADDR_W  = 23;
    localparam int     DATA_W  = 16;
    localparam int     DEPTH   = 4;
    localparam longint PC_MASK = (longint'(1) << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pcinc = 1'b0;
    logic              pcload = 1'b0;
    logic              branch = 1'b0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [DATA_W-1:0] boffs = '0;
    logic [DATA_W-1:0] databus = '0;
    logic [ADDR_W:0]   pc_addr;
    logic              busy;
    logic [2:0]        stk_cnt;
    logic              ovf;
    logic              unf;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    pc_stack_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INC_STEP(2), .STACK_DEPTH(DEPTH), .RESET_VEC(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .pcinc_i(pcinc), .pcload_i(pcload),
        .branch_i(branch), .boffs_i(boffs), .call_i(call), .ret_i(ret),
        .databus_i(databus), .pc_addr_o(pc_addr), .busy_o(busy),
        .stk_cnt_o(stk_cnt), .stk_ovf_o(ovf), .stk_unf_o(unf)
    );

    // Reference model: PC as an integer, stack as a queue, load phase 0/1/2.
    longint m_pc = 0;
    longint m_lo = 0;
    int     m_phase = 0;
    longint m_stack[$];
    bit     m_ovf = 1'b0;
    bit     m_unf = 1'b0;

    function automatic longint sext16(input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] s;
        s = v;
        return longint'(s);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_lo = 0; m_phase = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (m_phase == 1) begin
            m_lo = longint'(databus) & 64'hFFFE;
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_pc = ((longint'(databus) << DATA_W) | m_lo) & PC_MASK;
            m_phase = 0;
        end else if (ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else m_unf = 1'b1;
        end else if (call) begin
            if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 2) & PC_MASK);
            else m_ovf = 1'b1;
            m_phase = 1;
        end else if (pcload) begin
            m_phase = 1;
        end else if (branch) begin
            m_pc = (m_pc + 2 + 2 * sext16(boffs)) & PC_MASK & ~longint'(1);
        end else if (pcinc) begin
            m_pc = (m_pc + 2) & PC_MASK;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("model_pc", 64'(pc_addr), 64'(m_pc));
            check("model_busy", 64'(busy), 64'(m_phase != 0));
            check("model_cnt", 64'(stk_cnt), 64'(m_stack.size()));
            check("model_ovf", 64'(ovf), 64'(m_ovf));
            check("model_unf", 64'(unf), 64'(m_unf));
        end
    end

    task automatic pulse(input bit r, input bit c, input bit b, input bit i,
                         input logic [DATA_W-1:0] off);
        ret = r; call = c; branch = b; pcinc = i; boffs = off;
        @(negedge clk);
        ret = 0; call = 0; branch = 0; pcinc = 0; boffs = '0;
    endtask

    // Two-word load or call; optionally holds pcinc high while busy.
    task automatic two_word(input bit is_call, input logic [DATA_W-1:0] lo,
                            input logic [DATA_W-1:0] hi, input bit inc_busy,
                            input logic [63:0] old_pc);
        if (is_call) call = 1'b1; else pcload = 1'b1;
        @(negedge clk);
        call = 1'b0; pcload = 1'b0; pcinc = inc_busy; databus = lo;
        check("busy_lo", 64'(busy), 64'd1);
        check("hold_lo", 64'(pc_addr), old_pc);
        @(negedge clk);
        databus = hi;
        check("busy_hi", 64'(busy), 64'd1);
        check("hold_hi", 64'(pc_addr), old_pc);
        @(negedge clk);
        pcinc = 1'b0; databus = '0;
        check("busy_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev;
        logic [63:0] ret_exp [4];
        repeat (2) @(negedge clk);
        check("rst_pc", 64'(pc_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(stk_cnt), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_unf", 64'(unf), 64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            pulse(0, 0, 0, 1, '0);
            check("inc", 64'(pc_addr), 64'(2 * i));
        end

        pcinc = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_pc", 64'(pc_addr), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        pcinc = 1'b0;
        rst_n = 1'b1;

        two_word(0, 16'h1235, 16'h0042, 0, 64'h0);
        check("load", 64'(pc_addr), 64'h421234);

        two_word(0, 16'h0100, 16'h0000, 0, 64'h421234);
        check("load_100", 64'(pc_addr), 64'h100);
        pulse(0, 0, 1, 0, 16'hFFFE);
        check("branch_neg", 64'(pc_addr), 64'h0FE);
        pulse(0, 0, 1, 0, 16'h0010);
        check("branch_pos", 64'(pc_addr), 64'h120);
        two_word(0, 16'hFFFE, 16'h007F, 0, 64'h120);
        check("load_top", 64'(pc_addr), 64'h7FFFFE);
        pulse(0, 0, 0, 1, '0);
        check("inc_wrap", 64'(pc_addr), 64'h0);

        two_word(0, 16'h0200, 16'h0000, 0, 64'h0);
        two_word(1, 16'h0800, 16'h0000, 0, 64'h200);
        check("call_pc", 64'(pc_addr), 64'h800);
        check("call_cnt", 64'(stk_cnt), 64'd1);
        pulse(1, 0, 0, 0, '0);
        check("ret_pc", 64'(pc_addr), 64'h202);
        check("ret_cnt", 64'(stk_cnt), 64'd0);

        prev = 64'h202;
        for (int i = 1; i <= 5; i++) begin
            two_word(1, 16'(i * 16'h1000), 16'h0000, 0, prev);
            prev = 64'(i * 32'h1000);
            if (i == 4) check("ovf_before", 64'(ovf), 64'd0);
        end
        check("ovf_set", 64'(ovf), 64'd1);
        check("full_cnt", 64'(stk_cnt), 64'd4);
        check("ovf_pc", 64'(pc_addr), 64'h5000);
        ret_exp[0] = 64'h3002; ret_exp[1] = 64'h2002;
        ret_exp[2] = 64'h1002; ret_exp[3] = 64'h204;
        for (int i = 0; i < 4; i++) begin
            pulse(1, 0, 0, 0, '0);
            check("pop_pc", 64'(pc_addr), ret_exp[i]);
            check("pop_cnt", 64'(stk_cnt), 64'(3 - i));
        end
        check("unf_before", 64'(unf), 64'd0);
        pulse(1, 0, 0, 0, '0);
        check("unf_set", 64'(unf), 64'd1);
        check("unf_pc", 64'(pc_addr), 64'h204);
        check("unf_cnt", 64'(stk_cnt), 64'd0);

        two_word(0, 16'h0400, 16'h0000, 0, 64'h204);
        two_word(1, 16'h0600, 16'h0000, 0, 64'h400);
        pulse(1, 0, 1, 1, 16'h0100);
        check("prio_ret_pc", 64'(pc_addr), 64'h402);
        check("prio_ret_cnt", 64'(stk_cnt), 64'd0);

        two_word(0, 16'h0A00, 16'h0001, 1, 64'h402);
        check("busy_inc_ignored", 64'(pc_addr), 64'h010A00);

        for (int n = 0; n < 200; n++) begin
            ret = ($urandom_range(0, 5) == 0);
            call = ($urandom_range(0, 5) == 0);
            pcload = ($urandom_range(0, 5) == 0);
            branch = ($urandom_range(0, 3) == 0);
            pcinc = ($urandom_range(0, 1) == 0);
            boffs = 16'($urandom_range(0, 16'hFFFF));
            databus = 16'($urandom_range(0, 16'hFFFF));
            @(negedge clk);
        end
        ret = 0; call = 0; pcload = 0; branch = 0; pcinc = 0;
        boffs = '0; databus = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
